sevseg_mux_drv: RTL

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It consumes the four 7-bit segment patterns held by the wishbone hex register block (hex0..hex3) and drives one shared active-low segment bus plus four active-low digit enables. It sits between that register block and the board pins. It scans one digit per slot and inserts a blanking interval at the start of each slot to suppress ghosting.

---
 rtl/sevseg_pkg.sv | 25 ++
 rtl/sevseg_slot_timer.sv | 91 +++++++++
 rtl/sevseg_mux_drv.sv | 112 +++++++++++
 3 files changed

// File: rtl/sevseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sevseg_pkg
// Description : Shared types and constants for the 4-digit seven-segment
//               multiplexed display driver.
// Revision    : 1.0 - initial release
// ============================================================================
package sevseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;

    typedef logic [SEG_W-1:0] seg_t;
    typedef logic [1:0]       dig_idx_t;

    localparam seg_t                  SEG_BLANK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_BLANK  = 4'hF;

    // Active-low one-hot anode select for the given digit.
    function automatic logic [NUM_DIGITS-1:0] an_select_n(input dig_idx_t sel);
        return ~(NUM_DIGITS'(1) << sel);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sevseg_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : sevseg_slot_timer
// Description : Slot divider and digit index for the multiplexed display.
//               With SEVSEG_DIMMING_EN defined it also tracks the 16-phase
//               position within the lit part of each slot.
// Revision    : 1.0 - initial release
// ============================================================================
module sevseg_slot_timer
    import sevseg_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             en,
    output logic [CNT_W-1:0] div_cnt,
    output dig_idx_t         idx,
    output logic             slot_start,
    output logic             frame_end
`ifdef SEVSEG_DIMMING_EN
    ,
    output logic [4:0]       phase
`endif
);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_C   = CNT_W'(BLANK_CYCLES);

    logic slot_end;

    assign slot_start = (div_cnt == '0);
    assign slot_end   = (div_cnt == SLOT_LAST);
    assign frame_end  = en && slot_end && (idx == 2'd3);

    // Disabling the display parks the scan at the start of digit 0.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (!en) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

`ifdef SEVSEG_DIMMING_EN
    localparam int                 LIT_CYCLES = CLK_DIV - BLANK_CYCLES;
    localparam int                 ACC_W      = CNT_W + 5;
    localparam logic [ACC_W-1:0]   LIT_C      = ACC_W'(LIT_CYCLES);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [4:0]       step;

    // phase = floor(16*k / LIT_CYCLES) tracked incrementally: each lit cycle
    // adds 16 to the remainder and carries whole multiples of LIT_CYCLES.
    always_comb begin
        acc_nxt = acc + ACC_W'(16);
        step    = '0;
        for (int i = 0; i < 17; i++) begin
            if (acc_nxt >= LIT_C) begin
                acc_nxt = acc_nxt - LIT_C;
                step    = step + 5'd1;
            end
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            phase <= '0;
            acc   <= '0;
        end else if (!en || slot_end || (div_cnt < BLANK_C)) begin
            phase <= '0;
            acc   <= '0;
        end else begin
            phase <= phase + step;
            acc   <= acc_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/sevseg_mux_drv.sv
`default_nettype none
// ============================================================================
// Module      : sevseg_mux_drv
// Description : Time-multiplexed driver for a 4-digit common-anode seven-
//               segment display with per-slot anti-ghosting blanking.
//               Define SEVSEG_DIMMING_EN to add the brightness input.
// Revision    : 1.0 - initial release
// ============================================================================
module sevseg_mux_drv
    import sevseg_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    input  logic       en,
`ifdef SEVSEG_DIMMING_EN
    input  logic [3:0] brightness,
`endif
    input  logic [6:0] hex0,
    input  logic [6:0] hex1,
    input  logic [6:0] hex2,
    input  logic [6:0] hex3,
    output logic [6:0] seg_n,
    output logic [3:0] an_n,
    output logic       frame_tick
);

    localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] div_cnt;
    dig_idx_t         idx;
    logic             slot_start;
    logic             frame_end;
    seg_t             hex_sel;
    seg_t             pat;
    seg_t             pat_eff;
    logic             lit;

`ifdef SEVSEG_DIMMING_EN
    logic [4:0] phase;
    logic [3:0] bright;
`endif

    sevseg_slot_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_slot_timer (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .en         (en),
        .div_cnt    (div_cnt),
        .idx        (idx),
        .slot_start (slot_start),
        .frame_end  (frame_end)
`ifdef SEVSEG_DIMMING_EN
        ,
        .phase      (phase)
`endif
    );

    always_comb begin
        case (idx)
            2'd0:    hex_sel = hex0;
            2'd1:    hex_sel = hex1;
            2'd2:    hex_sel = hex2;
            default: hex_sel = hex3;
        endcase
    end

    assign pat_eff = slot_start ? hex_sel : pat;

    always_comb begin
        lit = en && (div_cnt >= BLANK_C);
`ifdef SEVSEG_DIMMING_EN
        lit = lit && (phase <= {1'b0, bright});
`endif
    end

    // Pattern is latched once per slot so mid-slot register writes never tear.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            pat        <= '0;
            an_n       <= AN_BLANK;
            seg_n      <= SEG_BLANK;
            frame_tick <= 1'b0;
`ifdef SEVSEG_DIMMING_EN
            bright     <= '0;
`endif
        end else begin
            if (slot_start) begin
                pat    <= hex_sel;
`ifdef SEVSEG_DIMMING_EN
                bright <= brightness;
`endif
            end
            frame_tick <= frame_end;
            if (lit) begin
                an_n  <= an_select_n(idx);
                seg_n <= ~pat_eff;
            end else begin
                an_n  <= AN_BLANK;
                seg_n <= SEG_BLANK;
            end
        end
    end

endmodule
`default_nettype wire
